if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; drives pc/instruction/prediction straight into the decode stage (IF/ID register folded in).
- Fetches each instruction as four byte reads from the shared byte-wide memory port, little-endian assembly.
- Built-in 2-bit-counter branch predictor computes the next fetch pc; EX redirects on mispredict and trains the predictor.

Parameters:
- RESET_PC, 32'h0, fetch pc after reset.
- PRED_IDX_W, 6, predictor index width (2^PRED_IDX_W counters, indexed by pc[PRED_IDX_W+1:2]).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset
- mem_grant  in  1  arbiter grant for this cycle's read
- mem_rd  out  1  byte read request
- mem_addr  out  32  byte address
- mem_rdata  in  8  read data, valid the cycle after a granted request
- stall_in  in  1  decode load-use stall; hold outputs
- ex_redirect  in  1  flush and refetch from ex_target
- ex_target  in  32  corrected pc
- ex_update  in  1  train predictor
- ex_update_pc  in  32  pc of the resolved branch
- ex_taken  in  1  resolved direction
- pc  out  32  pc of the presented instruction
- instruction  out  32  instruction word; 0 when bubble
- prediction  out  1  1 = predicted taken
- valid  out  1  presented instruction is real

Interface: reset rst, synchronous, active-low. All outputs registered.

Behaviour:
- Reset (rst=0 at any edge, mid-fetch included): state=FETCH, cnt=0, fpc=RESET_PC, mem_rd=0, pc=0, instruction=0, prediction=0, valid=0, all counters=2'b01. In-flight byte discarded.
- States: FETCH (issuing bytes 0..3, cnt counts granted issues), HOLD (word assembled, waiting for output slot).
- FETCH: mem_rd=1, mem_addr=fpc+cnt. Grant low: same address retried, cnt unchanged. Byte returning in cycle c+1 is stored to lane [8k+7:8k].
- The word is complete on the cycle byte 3 returns. Minimum 5 cycles from first issue to valid=1.
- Output slot update, each edge with stall_in=0:
  - A complete word loads: valid=1, pc=fpc, instruction=word, prediction=pred.
  - Otherwise a bubble loads: valid=0, instruction=0, prediction=0.
- stall_in=1: outputs hold. A completed word goes to HOLD with mem_rd=0. HOLD leaves at the first edge with stall_in=0, loading the held word.
- pred: JAL (opcode 1101111) = 1, target fpc+J_imm. B-type (1100011) = counter[idx][1], target fpc+B_imm. Everything else (incl. JALR) = 0.
- Next fpc = pred ? target : fpc+4. The next fetch starts the cycle after the word is loaded.
- Predictor training: ex_update increments (taken) or decrements the counter at ex_update_pc index, saturating at 00/11. Lookup and update of the same index in one cycle: lookup sees the old value.
- ex_redirect: highest priority over stall_in, HOLD and fetch completion.
  - Next edge: fpc=ex_target, state=FETCH, cnt=0, outputs become a bubble.
  - Any response to a request issued before the redirect is discarded.
- Address arithmetic is 32-bit modulo 2^32: fpc 0xFFFFFFFC+4 wraps to 0.

Optional Feature:
- Macro IF_PREDICT_EN.
- Defined: predictor as above.
- Undefined: counter array removed, ex_update/ex_update_pc/ex_taken ignored, prediction always 0, next fpc always fpc+4. EX redirects on every taken branch or jump.

Test Plan:
- Reset, memory at 0 = 13 05 10 00, grant always 1: mem_addr 0,1,2,3 on consecutive cycles; valid=1, pc=0, instruction=0x00100513 five cycles after first issue; next fetch at 0x4.
- mem_grant low 3 cycles during byte 2: mem_addr holds fpc+2; instruction intact; valid delayed 3 cycles.
- JAL 0x0080006F at pc 0x10: prediction=1; next mem_addr 0x18.
- BEQ at pc 0x20 with counter 01: prediction=0. Two ex_update taken cycles, refetch via ex_redirect to 0x20: prediction=1, next fpc 0x20+B_imm.
- stall_in held 6 cycles while a word completes: outputs frozen, mem_rd=0 in HOLD. Release: held word presented, then a bubble the next cycle.
- ex_redirect target 0x100 during byte 1 with stall_in=1: bubble next cycle, stale byte ignored, fetch restarts at 0x100. Reset asserted mid-fetch: all outputs 0, next fetch at RESET_PC.

Source files
------------

// File: rtl/if_fetch_if.sv
// if_fetch_if: byte-wide shared-memory read port used by the fetch stage.
// master = fetch side (issues requests), slave = arbiter/memory side.
interface if_fetch_if;
  logic        mem_grant;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;

  modport master (input mem_grant, input mem_rdata, output mem_rd, output mem_addr);
  modport slave  (output mem_grant, output mem_rdata, input mem_rd, input mem_addr);
endinterface

// File: rtl/if_fetch.sv
// if_fetch: RV32I fetch stage, four little-endian byte reads per word, IF/ID register folded in.
// Define IF_PREDICT_EN to build the 2-bit-counter branch predictor; otherwise next pc is always pc+4.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned PRED_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  if_fetch_if.master  bus,
  input  logic        stall_in,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        ex_update,
  input  logic [31:0] ex_update_pc,
  input  logic        ex_taken,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        prediction,
  output logic        valid
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] word_q, word_d, word_full;
  logic [31:0] next_fpc;
  logic        pend_q, pend_d;
  logic        load, pred, granted, complete;
  logic [1:0]  lane;

  // In HOLD the word is already assembled; in FETCH byte 3 is arriving on mem_rdata this cycle.
  assign word_full = (state_q == HOLD) ? word_q : {bus.mem_rdata, word_q[23:0]};
  assign granted   = bus.mem_rd & bus.mem_grant;
  assign complete  = (state_q == FETCH) && pend_q && (cnt_q == 3'd4);
  assign lane      = cnt_q[1:0] - 2'd1;

`ifdef IF_PREDICT_EN
  localparam int unsigned N_CTR  = 1 << PRED_IDX_W;
  localparam logic [6:0]  OP_JAL = 7'b1101111;
  localparam logic [6:0]  OP_BR  = 7'b1100011;

  logic [1:0]            ctr_q [N_CTR];
  logic [PRED_IDX_W-1:0] look_idx, upd_idx;
  logic [31:0]           j_imm, b_imm;
  logic                  unused_upd_bits;

  assign look_idx        = fpc_q[PRED_IDX_W+1:2];
  assign upd_idx         = ex_update_pc[PRED_IDX_W+1:2];
  assign unused_upd_bits = ^{ex_update_pc[31:PRED_IDX_W+2], ex_update_pc[1:0]};
  assign j_imm = {{12{word_full[31]}}, word_full[19:12], word_full[20], word_full[30:21], 1'b0};
  assign b_imm = {{20{word_full[31]}}, word_full[7], word_full[30:25], word_full[11:8], 1'b0};

  // Registered counters: a same-cycle lookup of the index being trained sees the old value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_CTR; i++) ctr_q[i] <= 2'b01;
    end else if (ex_update) begin
      if (ex_taken && ctr_q[upd_idx] != 2'b11)
        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
      else if (!ex_taken && ctr_q[upd_idx] != 2'b00)
        ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
    end
  end

  always_comb begin
    pred     = 1'b0;
    next_fpc = fpc_q + 32'd4;
    case (word_full[6:0])
      OP_JAL: begin
        pred     = 1'b1;
        next_fpc = fpc_q + j_imm;
      end
      OP_BR: begin
        pred = ctr_q[look_idx][1];
        if (pred) next_fpc = fpc_q + b_imm;
      end
      default: ;
    endcase
  end
`else
  logic unused_pred_inputs;

  assign unused_pred_inputs = ^{ex_update, ex_update_pc, ex_taken};
  assign pred               = 1'b0;
  assign next_fpc           = fpc_q + 32'd4;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fpc_d   = fpc_q;
    word_d  = word_q;
    pend_d  = 1'b0;
    load    = 1'b0;
    if (state_q == FETCH) begin
      if (pend_q) word_d[{lane, 3'b000} +: 8] = bus.mem_rdata;
      if (granted) begin
        cnt_d  = cnt_q + 3'd1;
        pend_d = 1'b1;
      end
      if (complete) begin
        if (stall_in) begin
          state_d = HOLD;
        end else begin
          load  = 1'b1;
          fpc_d = next_fpc;
          cnt_d = '0;
        end
      end
    end else if (!stall_in) begin
      load    = 1'b1;
      state_d = FETCH;
      fpc_d   = next_fpc;
      cnt_d   = '0;
    end
    // Redirect wins over everything; dropping pend_d discards the in-flight byte.
    if (ex_redirect) begin
      state_d = FETCH;
      fpc_d   = ex_target;
      cnt_d   = '0;
      pend_d  = 1'b0;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= FETCH;
      cnt_q        <= '0;
      fpc_q        <= RESET_PC;
      word_q       <= '0;
      pend_q       <= 1'b0;
      bus.mem_rd   <= 1'b0;
      bus.mem_addr <= '0;
      pc           <= '0;
      instruction  <= '0;
      prediction   <= 1'b0;
      valid        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fpc_q        <= fpc_d;
      word_q       <= word_d;
      pend_q       <= pend_d;
      bus.mem_rd   <= (state_d == FETCH) && (cnt_d != 3'd4);
      bus.mem_addr <= fpc_d + {29'd0, cnt_d};
      if (ex_redirect) begin
        valid       <= 1'b0;
        instruction <= '0;
        prediction  <= 1'b0;
      end else if (!stall_in) begin
        if (load) begin
          valid       <= 1'b1;
          pc          <= fpc_q;
          instruction <= word_full;
          prediction  <= pred;
        end else begin
          valid       <= 1'b0;
          instruction <= '0;
          prediction  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized bench for if_fetch with an instruction-level stream model and a
// scoreboard queue popped by an independent monitor.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_in = 1'b0, ex_redirect = 1'b0, ex_update = 1'b0, ex_taken = 1'b0;
  logic [31:0] ex_target = '0, ex_update_pc = '0;
  logic [31:0] pc, instruction;
  logic        prediction, valid;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(32'h0), .PRED_IDX_W(6)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_in(stall_in),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .ex_update(ex_update),
    .ex_update_pc(ex_update_pc), .ex_taken(ex_taken), .pc(pc),
    .instruction(instruction), .prediction(prediction), .valid(valid)
  );

  always #5 clk = ~clk;

  // Program image: byte view for the memory responder, word/kind/target view for the model.
  logic [7:0]  mem  [logic [31:0]];
  logic [31:0] wmem [logic [31:0]];
  int          kind [logic [31:0]];   // 1 = JAL, 2 = conditional branch
  logic [31:0] tgt  [logic [31:0]];
  logic [31:0] br_pcs [$];
  int          ctr [64];

  typedef struct {logic [31:0] pc; logic [31:0] ins; logic pr;} item_t;
  item_t expq [$];
  item_t it;

  int n_chk = 0, n_pass = 0, n_pop = 0;
  bit checking = 1'b0;
  logic e_stall = 1'b0, e_redir = 1'b0, e_rst = 1'b0;
  logic p_valid = 1'b0, p_pred = 1'b0;
  logic [31:0] p_pc = '0, p_ins = '0;

  function automatic logic [7:0] mb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic void put_word(input logic [31:0] a, input logic [31:0] w,
                                   input int k, input logic [31:0] t);
    wmem[a] = w; kind[a] = k; tgt[a] = t;
    for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
  endfunction

  function automatic logic [31:0] enc_jal(input logic [31:0] off);
    return {off[20], off[10:1], off[11], off[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input logic [31:0] off);
    return {off[12], off[10:5], 5'd0, 5'd0, 3'b000, off[4:1], off[11], 7'b1100011};
  endfunction

  task automatic chk(input string nm, input bit ok, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  // Walk the program from start, following predicted control flow, K instructions deep.
  task automatic push_stream(input logic [31:0] start, input int k);
    logic [31:0] p, nx;
    item_t e;
    p = start;
    for (int i = 0; i < k; i++) begin
      e.pc  = p;
      e.ins = wmem.exists(p) ? wmem[p] : 32'h0;
      e.pr  = 1'b0;
      nx    = p + 32'd4;
`ifdef IF_PREDICT_EN
      if (kind.exists(p) && kind[p] == 1) begin
        e.pr = 1'b1; nx = tgt[p];
      end else if (kind.exists(p) && kind[p] == 2 && ctr[p[7:2]] >= 2) begin
        e.pr = 1'b1; nx = tgt[p];
      end
`endif
      expq.push_back(e);
      p = nx;
    end
  endtask

  // Memory: a granted read returns its byte next cycle; other cycles carry garbage.
  always @(posedge clk) begin
    if (bus.mem_rd && bus.mem_grant) bus.mem_rdata <= mb(bus.mem_addr);
    else bus.mem_rdata <= 8'($urandom);
  end

  always @(posedge clk) begin
    e_stall = stall_in;
    e_redir = ex_redirect;
    e_rst   = rst;
  end

  always @(negedge clk) begin
    if (checking && e_rst && !e_redir) begin
      if (!e_stall) begin
        if (valid) begin
          if (expq.size() == 0) begin
            chk("extra_item", 1'b0, {1'b0, pc, instruction, prediction}, '0);
          end else begin
            it = expq.pop_front();
            n_pop++;
            chk("item", {pc, instruction, prediction} === {it.pc, it.ins, it.pr},
                {1'b0, pc, instruction, prediction}, {1'b0, it.pc, it.ins, it.pr});
          end
        end else begin
          chk("bubble", instruction == 32'h0 && prediction == 1'b0,
              {33'h0, instruction, prediction}, '0);
        end
      end else begin
        chk("stall_hold", {valid, pc, instruction, prediction} === {p_valid, p_pc, p_ins, p_pred},
            {valid, pc, instruction, prediction}, {p_valid, p_pc, p_ins, p_pred});
      end
      if (bus.mem_rd && expq.size() != 0)
        chk("fetch_addr", (bus.mem_addr - expq[0].pc) < 32'd4, {34'h0, bus.mem_addr}, {34'h0, expq[0].pc});
    end
    p_valid = valid; p_pc = pc; p_ins = instruction; p_pred = prediction;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic        rec_rd [16];
    logic [31:0] rec_addr [16], rec_pc [16], rec_ins [16];
    logic        rec_v [16];
    logic [31:0] w, off, target, bpc;
    int          fv, k, found;
    bit          tk;

    put_word(32'h00, 32'h00100513, 0, 32'h0);
    put_word(32'h04, 32'h00000013, 0, 32'h0);
    put_word(32'h08, 32'h00000013, 0, 32'h0);
    put_word(32'h0C, 32'h00000013, 0, 32'h0);
    put_word(32'h10, enc_jal(32'd8), 1, 32'h18);
    put_word(32'h14, 32'h00000013, 0, 32'h0);
    put_word(32'h18, 32'h00000013, 0, 32'h0);
    put_word(32'h1C, 32'h00000013, 0, 32'h0);
    put_word(32'h20, enc_br(32'd16), 2, 32'h30);
    br_pcs.push_back(32'h20);
    for (logic [31:0] a = 32'h24; a < 32'h200; a += 32'd4) begin
      k = $urandom_range(0, 9);
      w = $urandom;
      if (k <= 4) begin
        w[6:0] = 7'b0010011; put_word(a, w, 0, 32'h0);
      end else if (k <= 6) begin
        off = 32'($urandom_range(0, 24)) * 4 - 32'd48;
        put_word(a, enc_jal(off), 1, a + off);
      end else if (k <= 8) begin
        off = 32'($urandom_range(1, 24)) * 4 - 32'd52;
        put_word(a, enc_br(off), 2, a + off);
        br_pcs.push_back(a);
      end else begin
        w[6:0] = 7'b1100111; put_word(a, w, 0, 32'h0);
      end
    end
    put_word(32'hFFFF_FFF8, 32'h00000013, 0, 32'h0);
    put_word(32'hFFFF_FFFC, 32'h00000013, 0, 32'h0);
    for (int i = 0; i < 64; i++) ctr[i] = 1;

    // Reset state and first-word timing with grant always high.
    bus.mem_grant = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("reset_out", {valid, pc, instruction, prediction, bus.mem_rd} == '0,
        {valid, pc, instruction, prediction, bus.mem_rd}, '0);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rec_rd[i] = bus.mem_rd; rec_addr[i] = bus.mem_addr;
      rec_v[i] = valid; rec_pc[i] = pc; rec_ins[i] = instruction;
    end
    chk("idle_before_issue", rec_rd[0] == 1'b0, {65'h0, rec_rd[0]}, '0);
    for (int j = 0; j < 4; j++)
      chk("byte_addr", rec_rd[1+j] && rec_addr[1+j] == 32'(j), {34'h0, rec_addr[1+j]}, {34'h0, 32'(j)});
    fv = -1;
    for (int i = 11; i >= 0; i--) if (rec_v[i]) fv = i;
    chk("first_valid_latency", fv == 6, 66'(fv), 66'd6);
    chk("first_word", rec_v[6] && rec_pc[6] == 32'h0 && rec_ins[6] == 32'h00100513,
        {2'b0, rec_pc[6], rec_ins[6]}, {2'b0, 32'h0, 32'h00100513});
    chk("next_fetch_addr", rec_rd[6] && rec_addr[6] == 32'h4, {34'h0, rec_addr[6]}, 66'h4);

    // Stall held while the first word completes.
    rst = 1'b0; stall_in = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    repeat (8) cyc();
    @(negedge clk);
    chk("hold_no_rd", bus.mem_rd == 1'b0 && valid == 1'b0, {64'h0, bus.mem_rd, valid}, '0);
    cyc();
    stall_in = 1'b0;
    cyc();
    @(negedge clk);
    chk("held_word", valid && pc == 32'h0 && instruction == 32'h00100513 && !prediction,
        {1'b0, pc, instruction, prediction}, {1'b0, 32'h0, 32'h00100513, 1'b0});
    chk("after_hold_addr", bus.mem_rd && bus.mem_addr == 32'h4, {34'h0, bus.mem_addr}, 66'h4);
    cyc();
    @(negedge clk);
    chk("post_hold_bubble", !valid && instruction == 32'h0, {33'h0, instruction, valid}, '0);

    // Randomized phases: redirect (with training), then check a stream of K instructions.
    for (int ph = 0; ph < 30; ph++) begin
      cyc();
      checking = 1'b0;
      expq.delete();
      ex_redirect = 1'b1;
      if (ph == 0) target = 32'h10;
      else if (ph == 1) target = 32'h20;
      else if ($urandom_range(0, 9) == 0) target = 32'hFFFF_FFF8;
      else target = 32'($urandom_range(0, 127)) << 2;
      ex_target = target;
      stall_in = 1'($urandom_range(0, 1));
      bus.mem_grant = 1'($urandom_range(0, 1));
      k = (ph == 1) ? 2 : $urandom_range(0, 3);
      for (int t = 0; t < k; t++) begin
        bpc = (ph == 1) ? 32'h20 : br_pcs[$urandom_range(0, br_pcs.size() - 1)];
        tk  = (ph == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        ex_update = 1'b1; ex_update_pc = bpc; ex_taken = tk;
        if (tk) ctr[bpc[7:2]] = (ctr[bpc[7:2]] == 3) ? 3 : ctr[bpc[7:2]] + 1;
        else    ctr[bpc[7:2]] = (ctr[bpc[7:2]] == 0) ? 0 : ctr[bpc[7:2]] - 1;
        cyc();
      end
      ex_update = 1'b0;
      cyc();
      ex_redirect = 1'b0;
      k = $urandom_range(3, 8);
      push_stream(target, k);
      n_pop = 0;
      checking = 1'b1;
      for (int cy = 0; cy < 600 && n_pop < k; cy++) begin
        bus.mem_grant = ($urandom_range(0, 3) != 0);
        stall_in = ($urandom_range(0, 3) == 0);
        cyc();
      end
      checking = 1'b0;
      chk("phase_items", n_pop == k, 66'(n_pop), 66'(k));
    end

    // Reset in the middle of a fetch.
    stall_in = 1'b0; bus.mem_grant = 1'b1;
    ex_redirect = 1'b1; ex_target = 32'h40;
    cyc();
    ex_redirect = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    @(negedge clk);
    chk("midfetch_reset", {valid, pc, instruction, prediction, bus.mem_rd} == '0,
        {valid, pc, instruction, prediction, bus.mem_rd}, '0);
    for (int i = 0; i < 64; i++) ctr[i] = 1;
    cyc();
    rst = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (bus.mem_rd) found = 1;
    end
    chk("restart_addr", found == 1 && bus.mem_addr == 32'h0, {34'h0, bus.mem_addr}, '0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (valid) found = 1;
    end
    chk("restart_word", found == 1 && pc == 32'h0 && instruction == 32'h00100513,
        {2'b0, pc, instruction}, {2'b0, 32'h0, 32'h00100513});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
